dcache_wb_reader: RTL and testbench



---
 rtl/dcache_wb_reader_if.sv | 30 +++
 rtl/dcache_wb_reader.sv | 109 ++++++++++
 tb/tb_dcache_wb_reader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_reader_if.sv
// rtl/dcache_wb_reader_if.sv - start, BRAM read-port and beat-stream signals of the line write-back reader
interface dcache_wb_reader_if #(
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 7,
    parameter int LINE_WORDS = 4
);
    localparam int IDX_W = ADDR_SIZE - $clog2(LINE_WORDS);

    logic                 start_valid;
    logic [IDX_W-1:0]     start_idx;
    logic                 start_ready;
    logic                 enb;
    logic [ADDR_SIZE-1:0] addrb;
    logic [DATA_SIZE-1:0] doutb;
    logic                 m_valid;
    logic [DATA_SIZE-1:0] m_data;
    logic                 m_last;
    logic                 m_ready;
    logic                 done;

    modport slave (
        input  start_valid, start_idx, doutb, m_ready,
        output start_ready, enb, addrb, m_valid, m_data, m_last, done
    );

    modport master (
        output start_valid, start_idx, doutb, m_ready,
        input  start_ready, enb, addrb, m_valid, m_data, m_last, done
    );
endinterface

// File: rtl/dcache_wb_reader.sv
// rtl/dcache_wb_reader.sv - reads one cache line from BRAM and streams it out as beats
module dcache_wb_reader #(
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 7,
    parameter int LINE_WORDS = 4
) (
    input  logic clk,
    input  logic rstn,
    dcache_wb_reader_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = ADDR_SIZE - OFF_W;
    localparam int CNT_W = OFF_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]           state;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_W-1:0]     issue_cnt;
    logic [OFF_W-1:0]     beat_cnt;
    logic                 inflight;
    logic                 done_q;
    logic [DATA_SIZE-1:0] fifo_mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           occ;

    logic                 start_hs;
    logic                 pop;
    logic                 last_issue;
    logic                 last_pop;
    logic [1:0]           occ_proj;

    assign start_hs   = bus.start_valid && bus.start_ready;
    assign pop        = bus.m_valid && bus.m_ready;
    // Occupancy the FIFO will have once the word already on doutb lands and this cycle's pop leaves.
    assign occ_proj   = occ + {1'b0, inflight} - {1'b0, pop};
    assign last_issue = bus.enb && (issue_cnt == CNT_W'(LINE_WORDS - 1));
    assign last_pop   = pop && bus.m_last;

    assign bus.start_ready = (state == S_IDLE);
    assign bus.enb         = (state == S_READ) && (issue_cnt < CNT_W'(LINE_WORDS)) && (occ_proj < 2'd2);
    assign bus.addrb       = {idx_q, issue_cnt[OFF_W-1:0]};
    assign bus.m_valid     = (occ != 2'd0);
    assign bus.m_data      = fifo_mem[rd_ptr];
    assign bus.m_last      = bus.m_valid && (beat_cnt == OFF_W'(LINE_WORDS - 1));
    assign bus.done        = done_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            idx_q     <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            inflight  <= 1'b0;
            done_q    <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_hs) begin
                        state     <= S_READ;
                        idx_q     <= bus.start_idx;
                        issue_cnt <= '0;
                        beat_cnt  <= '0;
                    end
                end
                S_READ: begin
                    if (last_issue) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_pop) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (bus.enb) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            inflight <= bus.enb;

            if (pop) begin
                beat_cnt <= beat_cnt + 1'b1;
                rd_ptr   <= ~rd_ptr;
            end
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            occ <= occ_proj;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (inflight) begin
            fifo_mem[wr_ptr] <= bus.doutb;
        end
    end
endmodule

// File: tb/tb_dcache_wb_reader.sv
// tb/tb_dcache_wb_reader.sv - directed bench for dcache_wb_reader
module tb_dcache_wb_reader;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dcache_wb_reader_if #(.DATA_SIZE(32), .ADDR_SIZE(7), .LINE_WORDS(4)) bus ();

    dcache_wb_reader #(.DATA_SIZE(32), .ADDR_SIZE(7), .LINE_WORDS(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] mem [128];
    always @(posedge clk) begin
        if (bus.enb) bus.doutb <= mem[bus.addrb];
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] beats [$];
    logic [6:0]  addrs [$];
    int last_mask, first_valid_k, first_enb_k, last_enb_k, done_k, last_k;
    int stall_viol, ovf_viol, rdy_viol;
    bit done_rdy;
    logic [0:5] pat = 6'b100101;

    task automatic issue(input logic [4:0] idx);
        bit ok = 1'b0;
        for (int w = 0; w < 40 && !ok; w++) begin
            @(negedge clk);
            bus.start_valid = 1'b1;
            bus.start_idx   = idx;
            bus.m_ready     = 1'b1;
            #1;
            ok = bus.start_ready;
        end
        chk("start_accept", ok, 1);
    endtask

    task automatic collect(input bit mode, input bit hold, input logic [4:0] nidx, input int stop_after);
        int occ_m = 0;
        bit inf_m = 1'b0;
        bit pstall = 1'b0;
        logic [31:0] pdata = '0;
        bit plast = 1'b0;
        bit pop;
        beats.delete(); addrs.delete();
        last_mask = 0; first_valid_k = -1; first_enb_k = -1; last_enb_k = -1;
        done_k = -1; last_k = -1; stall_viol = 0; ovf_viol = 0; rdy_viol = 0; done_rdy = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            bus.m_ready     = mode ? pat[(k - 1) % 6] : 1'b1;
            bus.start_valid = hold;
            bus.start_idx   = nidx;
            #1;
            pop = bus.m_valid && bus.m_ready;
            if (bus.enb) begin
                addrs.push_back(bus.addrb);
                if (first_enb_k < 0) first_enb_k = k;
                last_enb_k = k;
                if (occ_m + int'(inf_m) - int'(pop) >= 2) ovf_viol++;
            end
            if (pstall && (!bus.m_valid || bus.m_data !== pdata || bus.m_last !== plast)) stall_viol++;
            if (bus.m_valid && first_valid_k < 0) first_valid_k = k;
            if (pop) begin
                if (bus.m_last) begin
                    last_mask |= 1 << beats.size();
                    last_k = k;
                end
                beats.push_back(bus.m_data);
            end
            if (bus.done) begin
                done_k   = k;
                done_rdy = bus.start_ready;
                return;
            end
            if (bus.start_ready) rdy_viol++;
            occ_m = occ_m + int'(inf_m) - int'(pop);
            inf_m = bus.enb;
            pstall = bus.m_valid && !bus.m_ready;
            pdata  = bus.m_data;
            plast  = bus.m_last;
            if (stop_after > 0 && beats.size() == stop_after) return;
        end
    endtask

    task automatic check_line(input string nm, input logic [127:0] exp, input logic [6:0] base);
        chk({nm, "_nbeats"}, beats.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_beat%0d", nm, i), (i < beats.size()) ? beats[i] : 64'hFFFF_FFFF_FFFF_FFFF,
                exp[i*32 +: 32]);
            chk($sformatf("%s_addr%0d", nm, i), (i < addrs.size()) ? addrs[i] : 64'hFFFF_FFFF_FFFF_FFFF,
                base + 7'(i));
        end
        chk({nm, "_naddr"}, addrs.size(), 4);
        chk({nm, "_last_mask"}, last_mask, 4'b1000);
        chk({nm, "_done_seen"}, done_k >= 0, 1);
        chk({nm, "_done_lat"}, done_k - last_k, 1);
        chk({nm, "_done_rdy"}, done_rdy, 1);
        chk({nm, "_stall"}, stall_viol, 0);
        chk({nm, "_ovf"}, ovf_viol, 0);
        chk({nm, "_busy_rdy"}, rdy_viol, 0);
    endtask

    initial begin
        int stray;
        for (int i = 0; i < 128; i++) mem[i] = i * 32'h11;
        bus.start_valid = 1'b0;
        bus.start_idx   = '0;
        bus.m_ready     = 1'b0;
        bus.doutb       = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_start_ready", bus.start_ready, 1);
        chk("rst_enb", bus.enb, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_done", bus.done, 0);
        @(negedge clk);
        rstn = 1'b1;

        issue(5'd3);
        collect(1'b0, 1'b0, 5'd0, 0);
        check_line("l3", {32'hFF, 32'hEE, 32'hDD, 32'hCC}, 7'd12);
        chk("l3_first_enb", first_enb_k, 1);
        chk("l3_last_enb", last_enb_k, 4);
        chk("l3_first_valid", first_valid_k, 3);
        chk("l3_last_beat", last_k, 6);

        issue(5'd3);
        collect(1'b1, 1'b0, 5'd0, 0);
        check_line("l3bp", {32'hFF, 32'hEE, 32'hDD, 32'hCC}, 7'd12);

        issue(5'd0);
        collect(1'b0, 1'b1, 5'd31, 0);
        check_line("l0", {32'h33, 32'h22, 32'h11, 32'h00}, 7'd0);
        collect(1'b0, 1'b0, 5'd0, 0);
        check_line("l31", {32'h86F, 32'h85E, 32'h84D, 32'h83C}, 7'd124);
        chk("l31_first_valid", first_valid_k, 3);

        issue(5'd3);
        collect(1'b0, 1'b0, 5'd0, 2);
        chk("rstmid_beats", beats.size(), 2);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("rstmid_m_valid", bus.m_valid, 0);
        chk("rstmid_enb", bus.enb, 0);
        chk("rstmid_done", bus.done, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.m_ready     = 1'b1;
            bus.start_valid = 1'b0;
            #1;
            if (bus.m_valid || bus.enb || bus.done) stray++;
        end
        chk("rstmid_quiet", stray, 0);

        issue(5'd3);
        collect(1'b0, 1'b0, 5'd0, 0);
        check_line("post_rst", {32'hFF, 32'hEE, 32'hDD, 32'hCC}, 7'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
